// File: rtl/bist_pattern_gen.sv
// BIST pattern generator: 16-bit Galois LFSR operand pairs for the multiplier under test,
// plus reset/enable sequencing of the signature compactor behind the multiplier latency.
module bist_pattern_gen #(
  parameter int          OPW       = 8,
  parameter int          NUM_PAIRS = 32,
  parameter logic [15:0] SEED      = 16'h8000,
  parameter int          RADIX_LAT = 2
) (
  input  logic           clk,
  input  logic           reset_to_tpg,
  input  logic           start,
  input  logic           hold,
  output logic [OPW-1:0] operand_a,
  output logic [OPW-1:0] operand_b,
  output logic           pattern_valid,
  output logic           misr_enable,
  output logic           reset_to_misr,
  output logic           busy,
  output logic           done,
  output logic [5:0]     pairs_sent
);

  // An all-zero seed would lock the LFSR, so it is swapped for 1.
  localparam logic [15:0] SEED_EFF  = (SEED == 16'h0000) ? 16'h0001 : SEED;
  localparam logic [15:0] LFSR_POLY = 16'h002D;
  localparam logic [5:0]  LAST_IDX  = 6'(NUM_PAIRS - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_RUN   = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic               w_issue;
  logic               w_inflight;
  logic [15:0]        r_lfsr;
  logic [OPW-1:0]     r_op_a;
  logic [OPW-1:0]     r_op_b;
  logic [5:0]         r_pairs;
  logic [RADIX_LAT:0] r_pipe;
  logic               r_rst_misr;
  logic               r_busy;
  logic               r_done;

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    lfsr_step = {v[14:0], 1'b0} ^ (v[15] ? LFSR_POLY : 16'h0000);
  endfunction

  // A result is still in flight if any stage except the output stage holds a valid.
  always_comb begin
    w_inflight = 1'b0;
    for (int i = 0; i < RADIX_LAT; i++) begin
      w_inflight = w_inflight | r_pipe[i];
    end
  end

  // Next-state and pair-issue decision.
  always_comb begin
    w_next  = r_state;
    w_issue = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) w_next = S_LOAD;
        else       w_next = S_IDLE;
      end
      S_LOAD: w_next = S_RUN;
      S_RUN: begin
        if (!hold) begin
          w_issue = 1'b1;
          if (r_pairs == LAST_IDX) w_next = S_DRAIN;
          else                     w_next = S_RUN;
        end else begin
          w_next = S_RUN;
        end
      end
      S_DRAIN: begin
        if (!w_inflight) w_next = S_DONE;
        else             w_next = S_DRAIN;
      end
      S_DONE: begin
        if (start) w_next = S_LOAD;
        else       w_next = S_DONE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // State, LFSR, operand and status registers; status reflects the state being entered.
  always_ff @(posedge clk or negedge reset_to_tpg) begin
    if (!reset_to_tpg) begin
      r_state    <= S_IDLE;
      r_lfsr     <= SEED_EFF;
      r_op_a     <= {OPW{1'b0}};
      r_op_b     <= {OPW{1'b0}};
      r_pairs    <= 6'd0;
      r_pipe     <= {(RADIX_LAT+1){1'b0}};
      r_rst_misr <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_busy     <= (w_next == S_LOAD) || (w_next == S_RUN) || (w_next == S_DRAIN);
      r_done     <= (w_next == S_DONE);
      r_rst_misr <= (w_next == S_RUN) || (w_next == S_DRAIN) || (w_next == S_DONE);
      r_pipe[0]  <= w_issue;
      for (int i = 1; i <= RADIX_LAT; i++) begin
        r_pipe[i] <= r_pipe[i-1];
      end
      if (r_state == S_LOAD) begin
        r_lfsr  <= SEED_EFF;
        r_pairs <= 6'd0;
      end else if (w_issue) begin
        r_op_a  <= r_lfsr[2*OPW-1:OPW];
        r_op_b  <= r_lfsr[OPW-1:0];
        r_lfsr  <= lfsr_step(r_lfsr);
        r_pairs <= r_pairs + 6'd1;
      end else begin
        r_lfsr  <= r_lfsr;
        r_pairs <= r_pairs;
      end
    end
  end

  assign operand_a     = r_op_a;
  assign operand_b     = r_op_b;
  assign pattern_valid = r_pipe[0];
  assign misr_enable   = r_pipe[RADIX_LAT];
  assign reset_to_misr = r_rst_misr;
  assign busy          = r_busy;
  assign done          = r_done;
  assign pairs_sent    = r_pairs;

endmodule

// File: tb/tb_bist_pattern_gen.sv
// Bench for bist_pattern_gen: default instance plus a (LAT=0, 1 pair, seed 0) instance,
// checked every cycle against a transaction-level model and pinned by literal values.
module tb_bist_pattern_gen;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start0 = 1'b0, hold0 = 1'b0, start1 = 1'b0, hold1 = 1'b0;
  logic [7:0] a0, b0, a1, b1;
  logic       pv0, me0, rm0, busy0, done0;
  logic       pv1, me1, rm1, busy1, done1;
  logic [5:0] ps0, ps1;

  always #5 clk = ~clk;

  bist_pattern_gen dut0 (
    .clk(clk), .reset_to_tpg(rst_n), .start(start0), .hold(hold0),
    .operand_a(a0), .operand_b(b0), .pattern_valid(pv0), .misr_enable(me0),
    .reset_to_misr(rm0), .busy(busy0), .done(done0), .pairs_sent(ps0)
  );

  bist_pattern_gen #(.OPW(8), .NUM_PAIRS(1), .SEED(16'h0000), .RADIX_LAT(0)) dut1 (
    .clk(clk), .reset_to_tpg(rst_n), .start(start1), .hold(hold1),
    .operand_a(a1), .operand_b(b1), .pattern_valid(pv1), .misr_enable(me1),
    .reset_to_misr(rm1), .busy(busy1), .done(done1), .pairs_sent(ps1)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Model: phase 0 idle, 1 load, 2 run, 3 drain, 4 done.
  int          m_lat[2]  = '{2, 0};
  int          m_np[2]   = '{32, 1};
  logic [15:0] m_seed[2] = '{16'h8000, 16'h0001};
  int          ph[2], cnt[2], drn[2];
  logic [7:0]  ea[2], eb[2];
  logic [7:0]  hist[2];

  function automatic logic [15:0] lfsr_nth(input logic [15:0] seed, input int n);
    logic [15:0] x;
    x = seed;
    for (int i = 0; i < n; i++) begin
      x = ((x * 2) & 16'hFFFF) ^ ((x >= 16'h8000) ? 16'h002D : 16'h0000);
    end
    return x;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      ph[k] = 0; cnt[k] = 0; drn[k] = 0;
      ea[k] = 8'h00; eb[k] = 8'h00; hist[k] = 8'h00;
    end
  endtask

  task automatic model_edge(input int k, input logic st, input logic hd);
    logic        issue;
    logic [15:0] pair;
    issue = 1'b0;
    case (ph[k])
      0, 4: if (st) ph[k] = 1;
      1: begin cnt[k] = 0; ph[k] = 2; end
      2: if (!hd) begin
        issue = 1'b1;
        pair  = lfsr_nth(m_seed[k], cnt[k]);
        ea[k] = pair[15:8];
        eb[k] = pair[7:0];
        cnt[k]++;
        if (cnt[k] == m_np[k]) begin ph[k] = 3; drn[k] = m_lat[k]; end
      end
      3: if (drn[k] == 0) ph[k] = 4; else drn[k]--;
      default: ;
    endcase
    hist[k] = {hist[k][6:0], issue};
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else begin
        model_edge(0, start0, hold0);
        model_edge(1, start1, hold1);
      end
    end
  end

  logic [15:0] obs0[$];
  logic [15:0] obs1[$];
  int          me_cnt0 = 0;

  task automatic cmp_dut(input int k, input logic [7:0] a, input logic [7:0] b, input logic pv,
                         input logic me, input logic rm, input logic bz, input logic dn,
                         input logic [5:0] ps);
    check($sformatf("d%0d_operand_a", k), a, ea[k]);
    check($sformatf("d%0d_operand_b", k), b, eb[k]);
    check($sformatf("d%0d_pattern_valid", k), pv, hist[k][0]);
    check($sformatf("d%0d_misr_enable", k), me, hist[k][m_lat[k]]);
    check($sformatf("d%0d_reset_to_misr", k), rm, ph[k] >= 2);
    check($sformatf("d%0d_busy", k), bz, ph[k] >= 1 && ph[k] <= 3);
    check($sformatf("d%0d_done", k), dn, ph[k] == 4);
    check($sformatf("d%0d_pairs_sent", k), ps, cnt[k]);
  endtask

  // Per-cycle comparison against the model and capture of issued pairs.
  initial begin
    forever begin
      @(negedge clk);
      cmp_dut(0, a0, b0, pv0, me0, rm0, busy0, done0, ps0);
      cmp_dut(1, a1, b1, pv1, me1, rm1, busy1, done1, ps1);
      if (pv0 === 1'b1) obs0.push_back({a0, b0});
      if (pv1 === 1'b1) obs1.push_back({a1, b1});
      if (me0 === 1'b1) me_cnt0++;
    end
  end

  task automatic wait_until(input int what, input int n, input string nm);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      #1;
      case (what)
        0: ok = (done0 === 1'b1);
        1: ok = (obs0.size() >= n);
        2: ok = (done1 === 1'b1);
        3: ok = (done0 === 1'b0);
        default: ok = 1'b1;
      endcase
    end
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL %s: got timeout expected condition within 300 cycles", nm);
    end
  endtask

  task automatic pulse_start0();
    @(negedge clk); start0 = 1'b1;
    @(negedge clk); start0 = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_operand_a", a0, 8'h00);
    check("rst_reset_to_misr", rm0, 1'b0);
    check("rst_busy", busy0, 1'b0);
    check("rst_pairs_sent", ps0, 6'd0);
    @(negedge clk); rst_n = 1'b1;

    // first pairs, full default run, and the single-pair zero-latency instance
    obs0.delete(); me_cnt0 = 0;
    @(negedge clk); start0 = 1'b1; start1 = 1'b1;
    @(negedge clk); start0 = 1'b0; start1 = 1'b0;
    wait_until(2, 0, "t6_done_wait");
    check("t6_pair_count", obs1.size(), 32'd1);
    check("t6_pair", obs1[0], 16'h0001);
    check("t6_pairs_sent", ps1, 6'd1);
    wait_until(0, 0, "t2_done_wait");
    check("t1_pair0", obs0[0], 16'h8000);
    check("t1_pair1", obs0[1], 16'h002D);
    check("t1_pair2", obs0[2], 16'h005A);
    check("t2_pair_count", obs0.size(), 32'd32);
    check("t2_misr_count", me_cnt0, 32'd32);
    check("t2_pairs_sent", ps0, 6'd32);

    // hold for three cycles after pair 5
    obs0.delete(); me_cnt0 = 0;
    pulse_start0();
    wait_until(1, 5, "t3_pair5_wait");
    hold0 = 1'b1;
    repeat (3) @(negedge clk);
    hold0 = 1'b0;
    wait_until(0, 0, "t3_done_wait");
    check("t3_pair_count", obs0.size(), 32'd32);
    check("t3_misr_count", me_cnt0, 32'd32);
    check("t3_pair5", obs0[5], lfsr_nth(16'h8000, 5));

    // asynchronous abort after pair 10, then a clean restart
    obs0.delete();
    pulse_start0();
    wait_until(1, 10, "t4_pair10_wait");
    #2 rst_n = 1'b0;
    #1;
    check("t4_operand_a", a0, 8'h00);
    check("t4_operand_b", b0, 8'h00);
    check("t4_pattern_valid", pv0, 1'b0);
    check("t4_misr_enable", me0, 1'b0);
    check("t4_reset_to_misr", rm0, 1'b0);
    check("t4_busy", busy0, 1'b0);
    check("t4_done", done0, 1'b0);
    check("t4_pairs_sent", ps0, 6'd0);
    @(negedge clk); rst_n = 1'b1;
    obs0.delete();
    pulse_start0();
    wait_until(1, 1, "t4_restart_wait");
    check("t4_restart_pair0", obs0[0], 16'h8000);
    wait_until(0, 0, "t4_done_wait");

    // start held high across two back-to-back runs
    obs0.delete();
    @(negedge clk); start0 = 1'b1;
    wait_until(3, 0, "t5_leave_done_wait");
    wait_until(0, 0, "t5_done1_wait");
    wait_until(3, 0, "t5_restart_wait");
    wait_until(0, 0, "t5_done2_wait");
    start0 = 1'b0;
    check("t5_pair_count", obs0.size(), 32'd64);
    check("t5_run2_pair0", obs0[32], 16'h8000);
    for (int i = 0; i < 32; i++) begin
      check($sformatf("t5_run2_pair%0d", i), obs0[32+i], lfsr_nth(16'h8000, i));
    end

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
